// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter and sequencer sharing one 16-bit SPI master.
// Defining SPI_ARB_TMO_EN adds a WAIT timeout that completes the frame with 16'hFFFF and tmo_err.
module spi_arb #(
  parameter int NUM_REQ = 3,
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] cmd_in,
  output logic [NUM_REQ-1:0]    ack,
  output logic [15:0]           rd_data_out,
  output logic                  busy,
  output logic                  tmo_err,
  output logic                  spi_wrt,
  output logic [15:0]           spi_cmd,
  input  logic                  spi_done,
  input  logic [15:0]           spi_rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ACK, GAP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [15:0]        cmd_q, cmd_d;
  logic [15:0]        rd_q, rd_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               wrt_q, wrt_d;
  logic               first_q, first_d;
  logic [7:0]         gap_q, gap_d;
  logic               done_q;
  logic               done_rise;
  logic               tmo_hit;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [IDX_W:0]     rr_sum;
  logic [IDX_W-1:0]   rr_idx;
  logic [15:0]        cmd_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
    assign cmd_arr[gi] = cmd_in[16*gi +: 16];
  end

  assign done_rise = spi_done & ~done_q;

  // Scan upward from the requester after the last one served, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_q} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[IDX_W-1:0];
      if (!pick_vld && req[rr_idx]) begin
        pick_vld = 1'b1;
        pick     = rr_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    ack_d   = '0;
    wrt_d   = 1'b0;
    first_d = 1'b0;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          cmd_d   = cmd_arr[pick];
          wrt_d   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        first_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // The first WAIT cycle may still see done from the previous frame.
        if (!first_q && done_rise) begin
          rd_d         = spi_rd_data;
          ack_d[gnt_q] = 1'b1;
          state_d      = ACK;
        end else if (tmo_hit) begin
          rd_d         = 16'hFFFF;
          ack_d[gnt_q] = 1'b1;
          state_d      = ACK;
        end
      end
      ACK: begin
        last_d  = gnt_q;
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == 8'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cmd_q   <= '0;
      rd_q    <= '0;
      ack_q   <= '0;
      wrt_q   <= 1'b0;
      first_q <= 1'b0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      wrt_q   <= wrt_d;
      first_q <= first_d;
      gap_q   <= gap_d;
      done_q  <= spi_done;
    end
  end

`ifdef SPI_ARB_TMO_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_q;

  assign tmo_hit = (state_q == WAIT) && (tmo_cnt_q == 16'(TMO_CYC - 1));

  // Counter is zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == WAIT) ? tmo_cnt_q + 16'd1 : 16'd0;
      tmo_q     <= tmo_hit && !(!first_q && done_rise);
    end
  end

  assign tmo_err = tmo_q;
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign tmo_err    = 1'b0;
  assign unused_tmo = (TMO_CYC > 0);
`endif

  assign ack         = ack_q;
  assign rd_data_out = rd_q;
  assign busy        = (state_q != IDLE);
  assign spi_wrt     = wrt_q;
  assign spi_cmd     = cmd_q;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus randomized round-robin traffic
// against a transaction-level model; the SPI master is emulated by the bench.
module tb_spi_arb;
  localparam int NUM_REQ = 3;
  localparam int GAP_CYC = 4;
  localparam int TMO_CYC = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] cmd_in;
  logic [NUM_REQ-1:0]    ack;
  logic [15:0]           rd_data_out;
  logic                  busy;
  logic                  tmo_err;
  logic                  spi_wrt;
  logic [15:0]           spi_cmd;
  logic                  spi_done;
  logic [15:0]           spi_rd_data;

  spi_arb #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd_in(cmd_in), .ack(ack),
    .rd_data_out(rd_data_out), .busy(busy), .tmo_err(tmo_err),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done),
    .spi_rd_data(spi_rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int last_m;
  logic [15:0] cmds     [NUM_REQ];
  logic [15:0] nxt_cmds [NUM_REQ];

  int   cyc      = 0;
  int   last_wrt = -1000;
  int   ack_cnt  = 0;
  logic wrt_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] r);
    int i;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (last + k) % NUM_REQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply_cmds();
    for (int i = 0; i < NUM_REQ; i++) cmd_in[16*i +: 16] = cmds[i];
  endtask

  task automatic wait_wrt(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      seen = spi_wrt;
    end
    if (!seen) check("wrt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    spi_done = 1'b0;
    spi_rd_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    last_m = NUM_REQ - 1;
  endtask

  // One complete transaction: grant expected by round-robin over the current req,
  // done raised dly clocks after wrt, optional req/cmd change at chg_t.
  task automatic run_txn(input int dly, input bit stale, input logic [15:0] rd,
                         input int chg_t, input logic [NUM_REQ-1:0] new_req,
                         input logic [NUM_REQ-1:0] pulse);
    int exp_i;
    int a0;
    bit seen;
    logic [15:0] exp_cmd;
    logic [NUM_REQ-1:0] one_hot;
    exp_i = rr_pick(last_m, req);
    if (exp_i < 0) return;
    exp_cmd = cmds[exp_i];
    one_hot = '0;
    one_hot[exp_i] = 1'b1;
    a0 = ack_cnt;
    wait_wrt(seen);
    if (!seen) return;
    check("launch_cmd", 32'(spi_cmd), 32'(exp_cmd));
    check("launch_busy", 32'(busy), 32'd1);
    if (!stale) spi_done = 1'b0;
    for (int t = 1; t <= dly; t++) begin
      tick();
      check("wait_quiet", 32'({spi_wrt, ack}), 32'd0);
      if (stale && t == 2) spi_done = 1'b0;
      if (t == chg_t) begin
        req = new_req | pulse;
        cmds = nxt_cmds;
        apply_cmds();
      end
      if (t == chg_t + 1) req = new_req;
      if (t == dly) begin
        spi_done = 1'b1;
        spi_rd_data = rd;
      end
    end
    tick();
    check("ack", 32'(ack), 32'(one_hot));
    check("rd_data", 32'(rd_data_out), 32'(rd));
    check("tmo_clear", 32'(tmo_err), 32'd0);
    check("cmd_hold", 32'(spi_cmd), 32'(exp_cmd));
    last_m = exp_i;
    for (int g = 0; g < GAP_CYC; g++) begin
      tick();
      check("gap_busy", 32'({busy, ack}), 32'(1 << NUM_REQ));
    end
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("ack_count", 32'(ack_cnt - a0), 32'd1);
  endtask

  // Protocol monitor: wrt width/spacing, ack one-hot, tmo_err only with ack.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (spi_wrt) begin
      check("wrt_width", 32'(wrt_prev), 32'd0);
      check("wrt_spacing", 32'((cyc - last_wrt) >= GAP_CYC + 3), 32'd1);
      last_wrt <= cyc;
    end
    if (ack != '0) begin
      check("ack_onehot", 32'($onehot(ack)), 32'd1);
      ack_cnt <= ack_cnt + 1;
    end
    if (tmo_err) check("tmo_with_ack", 32'(ack != '0), 32'd1);
    wrt_prev <= spi_wrt;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int cnt;
    int dly;
    rst_n = 1'b0;
    req = '0;
    cmd_in = '0;
    spi_done = 1'b0;
    spi_rd_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmds[i] = '0;
      nxt_cmds[i] = '0;
    end
    last_m = NUM_REQ - 1;
    repeat (3) tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wrt", 32'(spi_wrt), 32'd0);
    check("rst_cmd", 32'(spi_cmd), 32'd0);
    check("rst_rd", 32'(rd_data_out), 32'd0);
    check("rst_tmo", 32'(tmo_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request
    cmds[0] = 16'h8400;
    apply_cmds();
    nxt_cmds = cmds;
    req = 3'b001;
    run_txn(40, 1'b0, 16'h0A5C, 5, 3'b000, 3'b000);
    do_reset();

    // Round-robin with all requesters held
    cmds[0] = 16'h1111;
    cmds[1] = 16'h2222;
    cmds[2] = 16'h3333;
    apply_cmds();
    nxt_cmds = cmds;
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      run_txn(10, 1'b0, 16'(16'hA000 + n), 2, (n == 3) ? 3'b000 : 3'b111, 3'b000);
    end
    check("rr_last", 32'(last_m), 32'd0);

    // Stale done left high from the previous frame
    check("stale_pre", 32'(spi_done), 32'd1);
    req = 3'b001;
    run_txn(30, 1'b1, 16'h5A5A, 3, 3'b000, 3'b000);

    // Withdrawn pulse on req1, late req2 during WAIT
    req = 3'b001;
    run_txn(20, 1'b0, 16'h0101, 5, 3'b100, 3'b010);
    check("late_grant_pending", 32'(req), 32'b100);
    run_txn(10, 1'b0, 16'h0202, 3, 3'b000, 3'b000);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (spi_wrt) cnt++;
    end
    check("no_stray_grant", 32'(cnt), 32'd0);

    // Reset in the middle of WAIT
    req = 3'b001;
    run_txn(8, 1'b0, 16'h1234, 3, 3'b010, 3'b000);
    wait_wrt(seen);
    check("t5_cmd", 32'(spi_cmd), 32'(cmds[1]));
    spi_done = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_wrt", 32'(spi_wrt), 32'd0);
    check("mid_rst_rd", 32'(rd_data_out), 32'd0);
    check("mid_rst_cmd", 32'(spi_cmd), 32'd0);
    last_m = NUM_REQ - 1;
    req = 3'b111;
    run_txn(8, 1'b0, 16'h5678, 3, 3'b000, 3'b000);
    check("post_rst_prio", 32'(last_m), 32'd0);

    // Randomized traffic
    for (int i = 0; i < NUM_REQ; i++) cmds[i] = 16'($urandom);
    apply_cmds();
    req = 3'($urandom_range(1, 7));
    for (int n = 0; n < 24; n++) begin
      dly = $urandom_range(4, 20);
      for (int i = 0; i < NUM_REQ; i++) nxt_cmds[i] = 16'($urandom);
      run_txn(dly, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(2, dly),
              (n == 23) ? 3'b000 : 3'($urandom_range(1, 7)), 3'b000);
    end

    // spi_done never rises
    spi_done = 1'b1;
    tick();
    req = 3'b001;
    wait_wrt(seen);
    req = '0;
    spi_done = 1'b0;
`ifdef SPI_ARB_TMO_EN
    cnt = 0;
    for (int t = 1; t <= TMO_CYC; t++) begin
      tick();
      if (ack != '0 || tmo_err) cnt++;
    end
    check("tmo_early", 32'(cnt), 32'd0);
    tick();
    check("tmo_ack", 32'(ack), 32'b001);
    check("tmo_err", 32'(tmo_err), 32'd1);
    check("tmo_rd", 32'(rd_data_out), 32'hFFFF);
    tick();
    check("tmo_pulse", 32'(tmo_err), 32'd0);
    repeat (GAP_CYC) tick();
    check("tmo_idle", 32'(busy), 32'd0);
`else
    cnt = 0;
    for (int t = 0; t < 2000; t++) begin
      tick();
      if (!busy || tmo_err || ack != '0) cnt++;
    end
    check("no_tmo_hang", 32'(cnt), 32'd0);
    do_reset();
    tick();
    check("no_tmo_recover", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit SPI master between NUM_REQ requesters, for example the A2D line-sensor poller, the IMU reader and the motor-config block.
- For each transaction it does the following: picks a requester, captures its command, pulses the master's write strobe, waits for completion, returns the read data with a one-cycle ack, then enforces an inter-frame gap.
- Sits between the client blocks and the SPI master; it is the only driver of the master's wrt/cmd.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_CYC, 4, idle clocks between ack and the next grant; lets SS_n settle high (1..255).
- TMO_CYC, 1024, clocks allowed in WAIT before timeout; used only with the optional feature (2..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- req  in  NUM_REQ  per-requester request level
- cmd_in  in  16*NUM_REQ  packed commands; requester i uses bits [16*i+15:16*i]
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- rd_data_out  out  16  read data of the last completed transaction; held until the next completion
- busy  out  1  high in every state except IDLE
- tmo_err  out  1  one-cycle pulse, concurrent with ack, when a transaction timed out
- spi_wrt  out  1  write strobe to the SPI master
- spi_cmd  out  16  command to the SPI master; registered
- spi_done  in  1  SPI master done level (rises at the end of a frame, cleared by the master after wrt)
- spi_rd_data  in  16  SPI master read data

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - state=IDLE, ack=0, spi_wrt=0, spi_cmd=0, rd_data_out=0, busy=0, tmo_err=0.
  - last_gnt=NUM_REQ-1, so requester 0 has first priority.
  - Gap and timeout counters = 0.
- Reset mid-transaction: abandons the transaction with no ack. The SPI master is not touched beyond wrt=0.
- done_q is a register of spi_done; done_rise = spi_done & ~done_q.
- States: IDLE, LAUNCH, WAIT, ACK, GAP.
- IDLE:
  - If req!=0, choose the first set bit scanning upward from last_gnt+1, wrapping modulo NUM_REQ.
  - Register gnt_idx and spi_cmd <= that requester's cmd_in slice; go to LAUNCH.
  - req is sampled only in IDLE.
- LAUNCH: spi_wrt=1 for exactly this one cycle; go to WAIT. Latency from req sampled in IDLE to spi_wrt high is 1 clock.
- WAIT:
  - done_rise is ignored in the first WAIT cycle, because the master's done may still be high from the previous frame.
  - Afterwards, done_rise -> ACK.
  - spi_cmd is held stable for the whole transaction.
- ACK (1 cycle):
  - ack[gnt_idx]=1.
  - rd_data_out <= spi_rd_data, visible the same cycle the ack is high (registered on ACK entry).
  - last_gnt <= gnt_idx. Go to GAP.
- GAP: count GAP_CYC clocks, then go to IDLE.
- Requester rules:
  - A requester must hold req and cmd_in stable until granted. After the grant, cmd_in and req changes are ignored.
  - Dropping req before the grant withdraws the request with no side effects.
  - A requester whose req is still high after its ack is serviced again, but only after the other pending requesters (round-robin).
- Simultaneous events:
  - A req rise during LAUNCH/WAIT/ACK/GAP is not lost; it is evaluated in the next IDLE.
  - A spi_done glitch during GAP/IDLE is ignored.
- Only one transaction is in flight at any time; ack is never multi-hot.

Optional Feature:
- Macro: SPI_ARB_TMO_EN.
- When defined:
  - A 16-bit counter runs in WAIT.
  - If it reaches TMO_CYC-1 without done_rise, go to ACK with rd_data_out <= 16'hFFFF and tmo_err=1 in the ack cycle, then GAP as normal.
  - The counter clears on entry to WAIT.
- When undefined:
  - WAIT waits indefinitely.
  - tmo_err is tied 0.
  - No counter logic is synthesized.

Test Plan:
1. Single request: req=3'b001, cmd0=16'h8400; the model raises spi_done 40 clocks after wrt with rd_data 16'h0A5C -> spi_wrt high 1 cycle, spi_cmd=16'h8400, then ack=3'b001 one cycle after the done rise, rd_data_out=16'h0A5C, busy low GAP_CYC+1 clocks later.
2. Round-robin: req=3'b111 held, cmds 16'h1111/16'h2222/16'h3333 -> spi_cmd order 1111,2222,3333,1111; acks 001,010,100,001; consecutive spi_wrt pulses are at least GAP_CYC+3 clocks apart.
3. Stale done: spi_done left high from the previous frame when the new wrt is issued, drops 2 clocks later, rises at 30 -> exactly one ack, generated at the 30-clock rise, not at launch.
4. Withdraw and late arrival: req1 pulses high for 1 cycle while the arbiter is in WAIT for req0 -> no grant to requester 1; req2 asserted during WAIT and held -> granted in the first IDLE after GAP.
5. Reset mid-WAIT: rst_n low for 1 clock at WAIT cycle 10 -> next cycle: state IDLE, ack=0, busy=0, spi_wrt=0, rd_data_out=0; requester 0 has priority again.
6. With SPI_ARB_TMO_EN and TMO_CYC=64: spi_done never rises -> ack plus tmo_err pulse TMO_CYC clocks after entering WAIT, rd_data_out=16'hFFFF; without the macro, busy stays high and tmo_err stays 0 for 2000 clocks.
